// File: rtl/mc_datapath_hs_if.sv
// Unified memory bus between the mc_datapath_hs core and a shared memory.
// Serves instruction fetch, load and store through one ready-stalled request port.
//   mem_req   : access request (core -> memory)
//   mem_we    : 1 = store, 0 = read; valid with mem_req
//   mem_adr   : byte address
//   mem_wdata : store data
//   mem_rdata : read data, valid in the mem_ready cycle (memory -> core)
//   mem_ready : transfer completes on a rising edge where mem_req && mem_ready
interface mc_datapath_hs_if #(
    parameter int unsigned DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_adr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_adr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/mc_datapath_hs.sv
// Multicycle MIPS-subset core: datapath and control FSM in one block, with a single
// ready-stalled memory port used for fetch, load and store.
// Supported: lw, sw, add, sub, and, or, slt, beq, addi, j.
// Optional feature macro MC_BNE_EN: when defined, bne (opcode 0x05) is a legal branch;
// otherwise it decodes as illegal.
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   mem        : memory bus (master side), see mc_datapath_hs_if
//   instr_done : one-cycle pulse on the final cycle of each instruction
//   illegal_op : one-cycle pulse on decode of an unsupported opcode/funct
//   state      : current FSM state encoding, for debug
module mc_datapath_hs #(
    parameter int unsigned          DATA_W     = 32,
    parameter logic [DATA_W-1:0]    RESET_PC   = '0,
    parameter int unsigned          NREGS_LOG2 = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    mc_datapath_hs_if.master        mem,
    output logic                    instr_done,
    output logic                    illegal_op,
    output logic [3:0]              state
);

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
`ifdef MC_BNE_EN
    localparam logic [5:0] OpBne   = 6'h05;
`endif

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
        StJump   = 4'd11
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] alu_out_q, alu_out_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Register file: not reset; register 0 is never written and always reads zero.
    logic [DATA_W-1:0]     rf_q [0:(1 << NREGS_LOG2) - 1];
    logic                  rf_we;
    logic [NREGS_LOG2-1:0] rf_waddr;
    logic [DATA_W-1:0]     rf_wdata;

    // Instruction fields
    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic [NREGS_LOG2-1:0] rs_idx;
    logic [NREGS_LOG2-1:0] rt_idx;
    logic [NREGS_LOG2-1:0] rd_idx;
    logic [DATA_W-1:0]     imm_sext;
    logic [DATA_W-1:0]     rs_val;
    logic [DATA_W-1:0]     rt_val;

    assign opcode   = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign rs_idx   = ir_q[21 +: NREGS_LOG2];
    assign rt_idx   = ir_q[16 +: NREGS_LOG2];
    assign rd_idx   = ir_q[11 +: NREGS_LOG2];
    assign imm_sext = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
    assign rs_val   = (rs_idx == '0) ? '0 : rf_q[rs_idx];
    assign rt_val   = (rt_idx == '0) ? '0 : rf_q[rt_idx];

    logic funct_ok;
    assign funct_ok = (funct == FnAdd) || (funct == FnSub) || (funct == FnAnd) ||
                      (funct == FnOr)  || (funct == FnSlt);

    logic slt_bit;
    assign slt_bit = $signed(a_q) < $signed(b_q);

    logic br_taken;
`ifdef MC_BNE_EN
    assign br_taken = (opcode == OpBne) ? (a_q != b_q) : (a_q == b_q);
`else
    assign br_taken = (a_q == b_q);
`endif

    logic              req_c;
    logic              we_c;
    logic [DATA_W-1:0] adr_c;
    logic              bad_op;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        alu_out_d  = alu_out_q;
        data_d     = data_q;
        req_c      = 1'b0;
        we_c       = 1'b0;
        adr_c      = pc_q;
        rf_we      = 1'b0;
        rf_waddr   = rt_idx;
        rf_wdata   = alu_out_q;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        bad_op     = 1'b0;

        case (state_q)
            StFetch: begin
                req_c = 1'b1;
                if (mem.mem_ready) begin
                    ir_d    = mem.mem_rdata[31:0];
                    pc_d    = pc_q + DATA_W'(4);
                    state_d = StDecode;
                end
            end
            StDecode: begin
                a_d       = rs_val;
                b_d       = rt_val;
                // pc already points past this instruction, so this is the branch target
                alu_out_d = pc_q + (imm_sext << 2);
                case (opcode)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype: begin
                        if (funct_ok) state_d = StExec;
                        else          bad_op  = 1'b1;
                    end
                    OpBeq:      state_d = StBranch;
`ifdef MC_BNE_EN
                    OpBne:      state_d = StBranch;
`endif
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJump;
                    default:    bad_op  = 1'b1;
                endcase
                if (bad_op) begin
                    illegal_op = 1'b1;
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end
            end
            StMemAdr: begin
                alu_out_d = a_q + imm_sext;
                state_d   = (opcode == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                req_c = 1'b1;
                adr_c = alu_out_q;
                if (mem.mem_ready) begin
                    data_d  = mem.mem_rdata;
                    state_d = StMemWb;
                end
            end
            StMemWb: begin
                rf_we      = 1'b1;
                rf_waddr   = rt_idx;
                rf_wdata   = data_q;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                req_c = 1'b1;
                we_c  = 1'b1;
                adr_c = alu_out_q;
                if (mem.mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end
            end
            StExec: begin
                case (funct)
                    FnSub:   alu_out_d = a_q - b_q;
                    FnAnd:   alu_out_d = a_q & b_q;
                    FnOr:    alu_out_d = a_q | b_q;
                    FnSlt:   alu_out_d = {{(DATA_W-1){1'b0}}, slt_bit};
                    default: alu_out_d = a_q + b_q;
                endcase
                state_d = StAluWb;
            end
            StAluWb: begin
                rf_we      = 1'b1;
                rf_waddr   = rd_idx;
                rf_wdata   = alu_out_q;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StAddiEx: begin
                alu_out_d = a_q + imm_sext;
                state_d   = StAddiWb;
            end
            StAddiWb: begin
                rf_we      = 1'b1;
                rf_waddr   = rt_idx;
                rf_wdata   = alu_out_q;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                if (br_taken) pc_d = alu_out_q;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StJump: begin
                pc_d       = {pc_q[DATA_W-1:28], ir_q[25:0], 2'b00};
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    // The FSM sits in FETCH during reset; gating with the reset level keeps the bus
    // idle until reset is released and drops a pending request immediately.
    assign mem.mem_req   = req_c & reset;
    assign mem.mem_we    = we_c & reset;
    assign mem.mem_adr   = adr_c;
    assign mem.mem_wdata = b_q;
    assign state         = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            data_q    <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rf_we && (rf_waddr != '0)) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_mc_datapath_hs.sv
// Directed bench for mc_datapath_hs: small program in a behavioural memory, checks of
// fetch addresses, stores, illegal decode, fetch stall and reset during a store.
module tb_mc_datapath_hs;

    logic        clk;
    logic        reset;
    logic        ready_en;
    logic        instr_done;
    logic        illegal_op;
    logic [3:0]  state;

    int checks = 0;
    int errors = 0;

    mc_datapath_hs_if #(.DATA_W(32)) bus ();

    mc_datapath_hs #(
        .DATA_W     (32),
        .RESET_PC   (32'h100),
        .NREGS_LOG2 (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem        (bus),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: reads combinational, stores only recorded.
    logic [31:0] mem_arr [0:255];
    logic [31:0] st_adr;
    logic [31:0] st_data;
    int          st_cnt = 0;
    int          done_cnt = 0;

    assign bus.mem_rdata = mem_arr[bus.mem_adr[9:2]];
    assign bus.mem_ready = ready_en;

    always @(posedge clk) begin
        if (bus.mem_req && bus.mem_we && bus.mem_ready) begin
            st_adr  <= bus.mem_adr;
            st_data <= bus.mem_wdata;
            st_cnt  <= st_cnt + 1;
        end
        if (instr_done) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Run the current instruction to completion, then check the next fetch.
    task automatic run_to_fetch(input string tag, input logic [31:0] exp_adr,
                                input logic exp_ill);
        int   n = 0;
        logic ill = 1'b0;
        while (!instr_done && n < 40) begin
            ill = ill | illegal_op;
            tick();
            n++;
        end
        ill = ill | illegal_op;
        check({tag, "_bound"}, 64'(n < 40), 64'd1);
        tick();
        check({tag, "_state"}, 64'(state), 64'd0);
        check({tag, "_adr"}, 64'(bus.mem_adr), 64'(exp_adr));
        check({tag, "_ill"}, 64'(ill), 64'(exp_ill));
    endtask

    task automatic check_store(input string tag, input logic [31:0] adr,
                               input logic [31:0] data);
        check({tag, "_st_adr"}, 64'(st_adr), 64'(adr));
        check({tag, "_st_data"}, 64'(st_data), 64'(data));
    endtask

    int sc;

    initial begin
        reset    = 1'b0;
        ready_en = 1'b1;
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
        mem_arr[64] = 32'h20010005; // 0x100 addi $1,$0,5
        mem_arr[65] = 32'h20020007; // 0x104 addi $2,$0,7
        mem_arr[66] = 32'h00221820; // 0x108 add  $3,$1,$2
        mem_arr[67] = 32'hAC030008; // 0x10C sw   $3,8($0)
        mem_arr[68] = 32'h8C040080; // 0x110 lw   $4,0x80($0)
        mem_arr[69] = 32'h00812822; // 0x114 sub  $5,$4,$1
        mem_arr[70] = 32'hAC050010; // 0x118 sw   $5,16($0)
        mem_arr[71] = 32'h2008FFFF; // 0x11C addi $8,$0,-1
        mem_arr[72] = 32'h0101482A; // 0x120 slt  $9,$8,$1
        mem_arr[73] = 32'hAC090014; // 0x124 sw   $9,20($0)
        mem_arr[74] = 32'h00225024; // 0x128 and  $10,$1,$2
        mem_arr[75] = 32'hAC0A0018; // 0x12C sw   $10,24($0)
        mem_arr[76] = 32'h00225825; // 0x130 or   $11,$1,$2
        mem_arr[77] = 32'hAC0B001C; // 0x134 sw   $11,28($0)
        mem_arr[78] = 32'h0041302A; // 0x138 slt  $6,$2,$1
        mem_arr[79] = 32'hAC060020; // 0x13C sw   $6,32($0)
        mem_arr[80] = 32'h08000008; // 0x140 j    0x20
        mem_arr[8]  = 32'h1022FFFE; // 0x20  beq  $1,$2,-2 (not taken)
        mem_arr[9]  = 32'h14220004; // 0x24  bne  $1,$2,+4
        mem_arr[10] = 32'hFC010800; // 0x28  opcode 0x3F, rt=rd=$1
        mem_arr[11] = 32'hAC010024; // 0x2C  sw   $1,36($0)
        mem_arr[12] = 32'h08000008; // 0x30  j    0x20
        mem_arr[14] = 32'h0800000A; // 0x38  j    0x28
        mem_arr[7]  = 32'h08000004; // 0x1C  j    0x10
        mem_arr[4]  = 32'h08000040; // 0x10  j    0x100
        mem_arr[32] = 32'h00000010; // 0x80  load data 16

        tick();
        tick();
        check("rst_req", 64'(bus.mem_req), 64'd0);
        check("rst_we", 64'(bus.mem_we), 64'd0);
        check("rst_state", 64'(state), 64'd0);
        check("rst_done", 64'(instr_done), 64'd0);

        @(negedge clk);
        reset = 1'b1;
        #1;
        check("fetch0_req", 64'(bus.mem_req), 64'd1);
        check("fetch0_we", 64'(bus.mem_we), 64'd0);
        check("fetch0_adr", 64'(bus.mem_adr), 64'h100);

        run_to_fetch("addi1", 32'h104, 1'b0);

        // Fetch stall: three cycles without ready, completes on the fourth
        ready_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_state", 64'(state), 64'd0);
            check("stall_adr", 64'(bus.mem_adr), 64'h104);
            check("stall_req", 64'(bus.mem_req), 64'd1);
        end
        ready_en = 1'b1;
        tick();
        check("stall_decode", 64'(state), 64'd1);

        run_to_fetch("addi2", 32'h108, 1'b0);
        run_to_fetch("add", 32'h10C, 1'b0);
        run_to_fetch("sw3", 32'h110, 1'b0);
        check_store("sw3", 32'h8, 32'd12);
        check("done_cnt4", 64'(done_cnt), 64'd4);
        run_to_fetch("lw", 32'h114, 1'b0);
        run_to_fetch("sub", 32'h118, 1'b0);
        run_to_fetch("sw5", 32'h11C, 1'b0);
        check_store("sw5", 32'h10, 32'd11);
        run_to_fetch("addim1", 32'h120, 1'b0);
        run_to_fetch("slt_neg", 32'h124, 1'b0);
        run_to_fetch("sw9", 32'h128, 1'b0);
        check_store("sw9", 32'h14, 32'd1);
        run_to_fetch("and", 32'h12C, 1'b0);
        run_to_fetch("sw10", 32'h130, 1'b0);
        check_store("sw10", 32'h18, 32'd5);
        run_to_fetch("or", 32'h134, 1'b0);
        run_to_fetch("sw11", 32'h138, 1'b0);
        check_store("sw11", 32'h1C, 32'd7);
        run_to_fetch("slt_ge", 32'h13C, 1'b0);
        run_to_fetch("sw6", 32'h140, 1'b0);
        check_store("sw6", 32'h20, 32'd0);
        run_to_fetch("j20", 32'h20, 1'b0);
        run_to_fetch("beq_nt", 32'h24, 1'b0);
`ifdef MC_BNE_EN
        run_to_fetch("bne_t", 32'h38, 1'b0);
        run_to_fetch("j28", 32'h28, 1'b0);
`else
        run_to_fetch("bne_ill", 32'h28, 1'b1);
`endif
        run_to_fetch("op3f", 32'h2C, 1'b1);
        run_to_fetch("sw1", 32'h30, 1'b0);
        check_store("sw1", 32'h24, 32'd5);

        mem_arr[8] = 32'h1021FFFE; // 0x20 beq $1,$1,-2 (taken)
        run_to_fetch("j20b", 32'h20, 1'b0);
        run_to_fetch("beq_t", 32'h1C, 1'b0);
        run_to_fetch("j10", 32'h10, 1'b0);
        run_to_fetch("j40", 32'h100, 1'b0);

        // Second pass up to the store, then reset while it is stalled in MEMWR
        run_to_fetch("addi1b", 32'h104, 1'b0);
        run_to_fetch("addi2b", 32'h108, 1'b0);
        run_to_fetch("addb", 32'h10C, 1'b0);
        tick();
        tick();
        ready_en = 1'b0;
        tick();
        check("memwr_state", 64'(state), 64'd5);
        check("memwr_req", 64'(bus.mem_req), 64'd1);
        check("memwr_we", 64'(bus.mem_we), 64'd1);
        check("memwr_adr", 64'(bus.mem_adr), 64'h8);
        check("memwr_wdata", 64'(bus.mem_wdata), 64'd12);
        sc = st_cnt;
        tick();
        check("memwr_hold", 64'(state), 64'd5);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_req", 64'(bus.mem_req), 64'd0);
        check("mid_rst_state", 64'(state), 64'd0);
        ready_en = 1'b1;
        tick();
        check("mid_rst_nostore", 64'(st_cnt), 64'(sc));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("restart_adr", 64'(bus.mem_adr), 64'h100);
        check("restart_req", 64'(bus.mem_req), 64'd1);
        run_to_fetch("post_rst", 32'h104, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_datapath_hs.md
Name: mc_datapath_hs

Overview:
Parametrised multicycle MIPS-subset core. It merges the datapath and its control state machine into one block and adds a ready-stalled memory handshake. A single unified memory port serves instruction fetch, load and store. It is the next generation of the unparametrised fixed-latency multicycle datapath/controller pair and sits between the top level and a shared memory model.

Parameters:
DATA_W, 32, datapath/register/address width; legal values 32 or 64; instruction word is always mem_rdata[31:0].
RESET_PC, 0, PC value loaded at reset.
NREGS_LOG2, 5, register-file address width; 32 registers; register 0 reads zero.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
mem_req  output  1  memory access request
mem_we  output  1  1 = store, 0 = read; valid with mem_req
mem_adr  output  DATA_W  byte address; PC in fetch, alu_out in load/store
mem_wdata  output  DATA_W  store data (B register)
mem_rdata  input  DATA_W  read data; valid in the mem_ready cycle
mem_ready  input  1  transfer completes on a rising edge where mem_req&&mem_ready
instr_done  output  1  one-cycle pulse on the final cycle of each instruction
illegal_op  output  1  one-cycle pulse on decode of an unsupported opcode/funct
state  output  4  current FSM state encoding, for debug

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_PC; FSM=FETCH; IR, A, B, alu_out and data regs = 0.
  - mem_req, mem_we, instr_done, illegal_op = 0.
  - Register-file contents are not reset; register 0 is hard zero.
- Supported instructions: lw(0x23), sw(0x2B), R-type(0x00: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A), beq(0x04), addi(0x08), j(0x02).
- States and transitions:
  - FETCH → DECODE once mem_ready is seen.
  - DECODE → MEMADR (lw/sw), EXEC (R), BRANCH (beq), ADDIEX (addi), JUMP (j), or FETCH with illegal_op (anything else).
  - MEMADR → MEMRD (lw) or MEMWR (sw).
  - MEMRD → MEMWB → FETCH.
  - MEMWR → FETCH.
  - EXEC → ALUWB → FETCH.
  - ADDIEX → ADDIWB → FETCH.
  - BRANCH → FETCH.
  - JUMP → FETCH.
- FETCH:
  - mem_req=1, mem_we=0, mem_adr=pc.
  - On the ready edge: IR<=mem_rdata[31:0], pc<=pc+4.
  - With mem_ready low, the FSM holds and outputs stay stable.
- DECODE:
  - A<=rf[rs], B<=rf[rt].
  - alu_out<=pc+(sext(imm)<<2), the branch target.
- Memory states:
  - MEMRD: mem_req=1, mem_we=0; holds until ready; data<=mem_rdata.
  - MEMWR: mem_req=1, mem_we=1, mem_wdata=B; holds until ready.
  - mem_adr=alu_out in both.
- Writeback:
  - MEMWB writes rf[rt]<=data.
  - ALUWB writes rf[rd]<=alu_out.
  - ADDIWB writes rf[rt]<=alu_out.
  - Any write to register 0 is discarded.
- BRANCH: if A==B, pc<=alu_out.
- JUMP: pc<={pc[DATA_W-1:28], instr[25:0], 2'b00}.
- Arithmetic:
  - Immediates are sign-extended to DATA_W.
  - add/sub wrap modulo 2^DATA_W with no overflow trap.
  - slt is a signed compare, result 0 or 1.
- instr_done is 1 on the edge leaving:
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH or JUMP;
  - DECODE when the opcode is illegal.
- mem_req=0 in every state other than FETCH, MEMRD and MEMWR. mem_ready is ignored while mem_req=0.
- A ready edge that coincides with reset assertion is dropped; after reset the core restarts fetch at RESET_PC.
- PC wraps modulo 2^DATA_W.

Optional Feature:
MC_BNE_EN:
- Defined: opcode 0x05 (bne) is legal and goes DECODE → BRANCH, taken when A!=B.
- Undefined: opcode 0x05 raises illegal_op and returns to FETCH with pc already advanced by 4.

Test Plan:
- Reset with RESET_PC=0x100, mem_ready=1 → first mem_adr=0x100 with mem_req=1 and mem_we=0; next fetch at 0x104.
- addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sw $3,8($0) → store at mem_adr=8 with mem_wdata=12; instr_done pulses 4 times.
- Fetch with mem_ready held low 3 cycles → FSM stays in FETCH, mem_adr/mem_req stable, IR captured only on the 4th cycle.
- beq $1,$1,-2 at 0x20 → next fetch at 0x1C; beq $1,$2 with unequal values → next fetch at 0x24.
- j 0x40 at pc 0x10 → next fetch at 0x100.
- Opcode 0x3F, and bne with MC_BNE_EN undefined → illegal_op pulse, no register write, next fetch at pc+4.
- Reset asserted mid-MEMWR → mem_req drops immediately; fetch restarts at RESET_PC.
